mux_bus_mem: RTL and testbench
==============================

Name: mux_bus_mem

Overview:
- Synthesizable memory target for the CPU's multiplexed 8-bit address/data bus (latch_hi/latch_lo/ind/write strobes); successor to the behavioural bench memory.
- Generalised memory depth, byte-addressed with aliasing.
- Log window at the top of the address space is backed by a LOG_DEPTH-entry 16-bit FIFO with status readback, overflow tracking and a host-side pop interface.
- Used in simulation benches and the FPGA bring-up harness.

Parameters:
- MEM_AW, 12: memory index width; depth = 2**MEM_AW bytes; higher address bits alias.
- LOG_DEPTH, 4: log FIFO entries; power of 2, at least 2.
- LOG_ADDR, 16'hFFFE: byte address of the log window; bit 0 must be 0; the window covers LOG_ADDR and LOG_ADDR+1.
- ROM_TOP, 16'h0100: write-protect boundary; used only with MBM_WPROT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- bus_do  in  8  CPU data/address output byte
- latch_hi  in  1  capture bus_do as address[15:8]
- latch_lo  in  1  capture bus_do[7:1] as address[7:1]
- ind  in  1  address bit 0
- write  in  1  write strobe
- bus_di  out  8  read data to the CPU
- log_valid  out  1  FIFO non-empty
- log_data  out  16  FIFO head entry, {hi, lo}
- log_pop  in  1  host consumes the head entry when log_valid=1
- log_clr  in  1  clears log_overflow
- log_count  out  $clog2(LOG_DEPTH)+1  FIFO occupancy
- log_overflow  out  1  sticky flag: a push was dropped
- wprot_err  out  1  sticky flag: a write to the protected region was dropped

Behaviour:
- Address capture (rising clk):
  - latch_hi=1 -> ahi <= bus_do; latch_lo=1 -> alo <= bus_do[7:1]; both may assert together.
  - Address A = {ahi, alo, ind}. The new value is visible in the cycle after capture; ind applies combinationally.
- Region decode: win = (A[15:1] == LOG_ADDR[15:1]). Otherwise memory index = A[MEM_AW-1:0].
- Memory read:
  - bus_di = mem[index], combinational from A.
  - Memory contents are not reset.
- Memory write: write=1 and !win -> mem[index] <= bus_do on rising clk. The written value is readable in the next cycle.
- Log window writes:
  - ind=0: byte0 <= bus_do.
  - ind=1: push {bus_do, byte0} into the FIFO.
  - Push when full and no pop in the same cycle: entry dropped, log_overflow <= 1, FIFO unchanged.
- Log window reads:
  - ind=0: bus_di = free slots (LOG_DEPTH - log_count), zero-extended.
  - ind=1: bus_di = {log_overflow, wprot_err, 5'b0, log_valid}.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo LOG_DEPTH.
  - log_data shows the head entry combinationally; it is don't-care when empty.
  - log_pop while empty is ignored.
  - Push and pop in the same cycle: both happen and count is unchanged. This includes the full case, where the push is accepted and overflow is not set.
  - Pop and push on empty in the same cycle: the pop is ignored and the push lands (count becomes 1).
- log_clr: log_overflow <= 0. If a dropped push occurs in the same cycle, set wins.
- Reset (async, rst=1), applies immediately, including mid-operation:
  - ahi, alo, byte0 = 0; FIFO pointers = 0.
  - log_count = 0, log_valid = 0, log_overflow = 0, wprot_err = 0.
  - bus_di then reflects mem[0].
  - Any strobe asserted during reset is ignored.
- Latency summary:
  - Read data is combinational from the captured address.
  - Write takes effect at the clk edge.
  - log_valid rises in the cycle after the pushing edge.

Optional Feature:
- Macro MBM_WPROT_EN.
- Defined: memory writes with A < ROM_TOP are dropped and set wprot_err (sticky until rst); log window writes are never protected.
- Undefined: all memory writes proceed and wprot_err is tied 0.

Test Plan:
- Write/read: latch_hi=0x01, latch_lo=0x22, ind=1, write 0xA5; then read with ind=1 -> bus_di=0xA5; ind=0 -> independent byte; address 0x1123 aliases to 0x0123 when MEM_AW=12.
- Log push: address 0xFFFE, write 0x34; ind=1, write 0x12 -> log_valid=1, log_data=0x1234, log_count=1; read ind=0 -> 0x03.
- Full/overflow: 5 pushes with LOG_DEPTH=4 and no pops -> log_count=4, log_overflow=1, head still the first entry; log_clr -> 0.
- Pop/push at full: full FIFO, push 0xBEEF with log_pop=1 -> count stays 4, no overflow, 0xBEEF at tail; pop 4 times -> order preserved including pointer wrap.
- Reset mid-stream: 2 entries queued, assert rst between edges -> log_valid=0, log_count=0, flags=0 immediately; a write strobe during rst is dropped.
- MBM_WPROT_EN: write 0x77 to 0x0010 -> memory unchanged, wprot_err=1; write to 0x0100 succeeds; without the macro the 0x0010 write lands and wprot_err=0.

Source files
------------

// File: rtl/mux_bus_mem_if.sv
// rtl/mux_bus_mem_if.sv - multiplexed CPU bus and log-FIFO host signals for mux_bus_mem
// Purpose: groups the CPU address/data strobes and the log FIFO host side.
// Parameter: LOG_DEPTH sets the width of log_count ($clog2(LOG_DEPTH)+1).
// master modport: CPU/host side (drives bus_do, strobes, log_pop, log_clr).
// slave modport : memory side (drives bus_di and the log status/data outputs).
interface mux_bus_mem_if #(
  parameter int LOG_DEPTH = 4
);
  localparam int CW = $clog2(LOG_DEPTH) + 1;

  logic [7:0]    bus_do;
  logic          latch_hi;
  logic          latch_lo;
  logic          ind;
  logic          write;
  logic [7:0]    bus_di;
  logic          log_valid;
  logic [15:0]   log_data;
  logic          log_pop;
  logic          log_clr;
  logic [CW-1:0] log_count;
  logic          log_overflow;
  logic          wprot_err;

  modport master (
    output bus_do, latch_hi, latch_lo, ind, write, log_pop, log_clr,
    input  bus_di, log_valid, log_data, log_count, log_overflow, wprot_err
  );

  modport slave (
    input  bus_do, latch_hi, latch_lo, ind, write, log_pop, log_clr,
    output bus_di, log_valid, log_data, log_count, log_overflow, wprot_err
  );
endinterface

// File: rtl/mux_bus_mem.sv
// rtl/mux_bus_mem.sv - byte memory and log FIFO behind the multiplexed 8-bit CPU bus
// Purpose: aliased 2**MEM_AW byte memory; a two-byte log window at LOG_ADDR
//   pushes 16-bit entries into a LOG_DEPTH FIFO drained by the host.
// Ports: clk, rst (async active-high); bus (mux_bus_mem_if.slave):
//   bus_do/latch_hi/latch_lo/ind/write in, bus_di out (combinational read),
//   log_pop/log_clr in, log_valid/log_data/log_count/log_overflow/wprot_err out.
// Optional macro MBM_WPROT_EN: drop memory writes below ROM_TOP and flag wprot_err.
module mux_bus_mem #(
  parameter int          MEM_AW    = 12,
  parameter int          LOG_DEPTH = 4,
  parameter logic [15:0] LOG_ADDR  = 16'hFFFE,
  parameter logic [15:0] ROM_TOP   = 16'h0100
) (
  input logic           clk,
  input logic           rst,
  mux_bus_mem_if.slave  bus
);
  localparam int PW = $clog2(LOG_DEPTH);
  localparam int CW = PW + 1;
  localparam int MEM_DEPTH = 2 ** MEM_AW;
  localparam logic [CW-1:0] DEPTH_C = CW'(LOG_DEPTH);
`ifdef MBM_WPROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic [7:0]    ahi_q, ahi_d;
  logic [6:0]    alo_q, alo_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          wprot_q, wprot_d;

  logic [7:0]    mem_q  [MEM_DEPTH];
  logic [15:0]   fifo_q [LOG_DEPTH];

  logic [15:0]       addr;
  logic [MEM_AW-1:0] idx;
  logic [CW-1:0]     free_slots;
  logic win, prot, mem_we, push, pop, full, empty, push_ok, drop;

  // Decode; !rst gates the array writes so strobes during reset are ignored.
  always_comb begin
    addr    = {ahi_q, alo_q, bus.ind};
    win     = (addr[15:1] == LOG_ADDR[15:1]);
    idx     = addr[MEM_AW-1:0];
    prot    = PROT_EN && (addr < ROM_TOP);
    mem_we  = !rst && bus.write && !win && !prot;
    empty   = (count_q == '0);
    full    = (count_q == DEPTH_C);
    pop     = bus.log_pop && !empty;
    push    = bus.write && win && bus.ind;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
  end

  always_comb begin
    ahi_d   = bus.latch_hi ? bus.bus_do : ahi_q;
    alo_d   = bus.latch_lo ? bus.bus_do[7:1] : alo_q;
    byte0_d = (bus.write && win && !bus.ind) ? bus.bus_do : byte0_q;
    wptr_d  = wptr_q + PW'(push_ok);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    ovf_d   = ovf_q;
    if (bus.log_clr) ovf_d = 1'b0;
    if (drop)        ovf_d = 1'b1;
    wprot_d = wprot_q | (bus.write && !win && prot);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ahi_q   <= '0;
      alo_q   <= '0;
      byte0_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      wprot_q <= 1'b0;
    end else begin
      ahi_q   <= ahi_d;
      alo_q   <= alo_d;
      byte0_q <= byte0_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      wprot_q <= wprot_d;
    end
  end

  // Storage arrays are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= bus.bus_do;
    if (push_ok && !rst) fifo_q[wptr_q] <= {bus.bus_do, byte0_q};
  end

  always_comb begin
    free_slots = DEPTH_C - count_q;
    if (win) begin
      bus.bus_di = bus.ind ? {ovf_q, wprot_q, 5'b0, !empty} : 8'(free_slots);
    end else begin
      bus.bus_di = mem_q[idx];
    end
  end

  assign bus.log_valid    = !empty;
  assign bus.log_data     = fifo_q[rptr_q];
  assign bus.log_count    = count_q;
  assign bus.log_overflow = ovf_q;
  assign bus.wprot_err    = wprot_q;
endmodule

// File: tb/tb_mux_bus_mem.sv
// tb/tb_mux_bus_mem.sv - scoreboard bench for mux_bus_mem with a queue-based reference model
module tb_mux_bus_mem;
  localparam int MEM_AW    = 12;
  localparam int LOG_DEPTH = 4;
`ifdef MBM_WPROT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_bus_mem_if #(.LOG_DEPTH(LOG_DEPTH)) bus ();

  mux_bus_mem #(.MEM_AW(MEM_AW), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  logic [7:0]  m_ahi;
  logic [6:0]  m_alo;
  logic [7:0]  m_b0;
  logic [15:0] fq[$];
  bit          m_ovf;
  bit          m_wp;
  logic [7:0]  mm[int];

  function automatic void push_exp(string name, int sel, logic [15:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    exp_q.push_back(e);
  endfunction

  function automatic logic [15:0] dut_val(int sel);
    case (sel)
      0:       return {8'h00, bus.bus_di};
      1:       return {15'h0, bus.log_valid};
      2:       return 16'(bus.log_count);
      3:       return {15'h0, bus.log_overflow};
      4:       return {15'h0, bus.wprot_err};
      default: return bus.log_data;
    endcase
  endfunction

  task automatic check_eq(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e   = exp_q.pop_front();
      act = dut_val(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $display("FAIL watchdog: stimulus did not complete by %0t", $time);
      $finish;
    end
  end

  function automatic void model_reset();
    m_ahi = 8'h00;
    m_alo = 7'h00;
    m_b0  = 8'h00;
    fq.delete();
    m_ovf = 1'b0;
    m_wp  = 1'b0;
  endfunction

  function automatic void expect_all();
    logic [15:0] a;
    int k;
    a = {m_ahi, m_alo, bus.ind};
    k = int'(a) % (2 ** MEM_AW);
    if (a >= 16'hFFFE) begin
      if (bus.ind) push_exp("status", 0, {8'h00, m_ovf, m_wp, 5'b0, fq.size() != 0});
      else         push_exp("free", 0, 16'(LOG_DEPTH - fq.size()));
    end else if (mm.exists(k)) begin
      push_exp("mem_rd", 0, {8'h00, mm[k]});
    end
    push_exp("log_valid", 1, {15'h0, fq.size() != 0});
    push_exp("log_count", 2, 16'(fq.size()));
    push_exp("log_overflow", 3, {15'h0, m_ovf});
    push_exp("wprot_err", 4, {15'h0, m_wp});
    if (fq.size() > 0) push_exp("log_data", 5, fq[0]);
  endfunction

  function automatic void model_step();
    logic [15:0] a;
    bit win, push, pop_ok, drop;
    a      = {m_ahi, m_alo, bus.ind};
    win    = (a >= 16'hFFFE);
    if (bus.write && !win) begin
      if (WP && a < 16'h0100) m_wp = 1'b1;
      else mm[int'(a) % (2 ** MEM_AW)] = bus.bus_do;
    end
    push   = bus.write && win && bus.ind;
    pop_ok = bus.log_pop && fq.size() > 0;
    drop   = push && fq.size() == LOG_DEPTH && !pop_ok;
    if (pop_ok) void'(fq.pop_front());
    if (push && !drop) fq.push_back({bus.bus_do, m_b0});
    if (bus.write && win && !bus.ind) m_b0 = bus.bus_do;
    if (bus.log_clr) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    if (bus.latch_hi) m_ahi = bus.bus_do;
    if (bus.latch_lo) m_alo = bus.bus_do[7:1];
  endfunction

  task automatic cyc(input logic [7:0] d, input bit lh, input bit ll, input bit id,
                     input bit wr, input bit pop, input bit clr);
    bus.bus_do   = d;
    bus.latch_hi = lh;
    bus.latch_lo = ll;
    bus.ind      = id;
    bus.write    = wr;
    bus.log_pop  = pop;
    bus.log_clr  = clr;
    expect_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic lat(input logic [7:0] hi, input logic [7:0] lo);
    cyc(hi, 1, 0, 0, 0, 0, 0);
    cyc(lo, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [7:0] d, input bit id);
    cyc(d, 0, 0, id, 1, 0, 0);
  endtask

  task automatic rd(input bit id);
    cyc(8'h00, 0, 0, id, 0, 0, 0);
  endtask

  task automatic log_push(input logic [15:0] v, input bit pop);
    wr(v[7:0], 0);
    cyc(v[15:8], 0, 0, 1, 1, pop, 0);
  endtask

  initial begin
    bus.bus_do = '0; bus.latch_hi = 0; bus.latch_lo = 0; bus.ind = 0;
    bus.write = 0; bus.log_pop = 0; bus.log_clr = 0;
    model_reset();
    @(posedge clk); #1;
    expect_all();
    @(posedge clk); #1;
    rst = 1'b0;

    wr(8'h11, 0);
    rd(0);
    cyc(8'h01, 1, 0, 0, 0, 0, 0);
    cyc(8'h22, 0, 1, 0, 0, 0, 0);
    wr(8'hA5, 1);
    rd(1);
    wr(8'h3C, 0);
    rd(0);
    rd(1);
    cyc(8'h11, 1, 0, 0, 0, 0, 0);
    rd(1);
    rd(0);

    cyc(8'hFF, 1, 1, 0, 0, 0, 0);
    cyc(8'hFE, 0, 1, 0, 0, 0, 0);
    log_push(16'h1234, 0);
    rd(0);
    rd(1);

    log_push(16'h5601, 0);
    log_push(16'h7802, 0);
    log_push(16'h9A03, 0);
    log_push(16'hBC04, 0);
    rd(0);
    rd(1);
    cyc(8'h00, 0, 0, 1, 0, 0, 1);
    rd(1);

    log_push(16'hBEEF, 1);
    rd(1);
    repeat (5) cyc(8'h00, 0, 0, 0, 0, 1, 0);
    rd(0);

    lat(8'h00, 8'h10);
    wr(8'h77, 0);
    rd(0);
    rd(1);
    lat(8'h01, 8'h00);
    wr(8'h66, 0);
    rd(0);

    lat(8'hFF, 8'hFE);
    log_push(16'h4321, 0);
    log_push(16'h8765, 0);
    rd(1);
    bus.bus_do = 8'hFF; bus.latch_hi = 1; bus.latch_lo = 1; bus.write = 1;
    bus.ind = 0; bus.log_pop = 0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_eq("rst_log_valid", {15'h0, bus.log_valid}, 16'h0000);
    check_eq("rst_log_count", 16'(bus.log_count), 16'h0000);
    check_eq("rst_log_overflow", {15'h0, bus.log_overflow}, 16'h0000);
    check_eq("rst_wprot_err", {15'h0, bus.wprot_err}, 16'h0000);
    expect_all();
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_strobe_dropped", 16'(bus.log_count), 16'h0000);
    rd(0);
    rd(1);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      bit lh, ll;
      d  = 8'($urandom);
      lh = ($urandom % 4) == 0;
      ll = ($urandom % 4) == 0;
      if ((lh || ll) && ($urandom % 2 == 1)) d = 8'hFF;
      cyc(d, lh, ll, 1'($urandom), ($urandom % 3) == 0, ($urandom % 3) == 0,
          ($urandom % 16) == 0);
    end

    rd(0);
    repeat (2) @(posedge clk);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
